// File: rtl/sockit_spi_dws_if.sv
// rtl/sockit_spi_dws_if.sv - word-in / chunk-out stream pair for sockit_spi_dws (SOCKIT_SPI_DWS_STRB_EN adds sdw_stb)
interface sockit_spi_dws_if #(
  parameter int DW = 32,
  parameter int SW = 8
);
  localparam int N = DW / SW;

  logic          sdw_vld;
  logic [DW-1:0] sdw_dat;
  logic          sdw_rdy;
  logic          sds_vld;
  logic [SW-1:0] sds_dat;
  logic          sds_rdy;
`ifdef SOCKIT_SPI_DWS_STRB_EN
  logic [N-1:0]  sdw_stb;

  modport slave (
    input  sdw_vld, sdw_dat, sdw_stb, sds_rdy,
    output sdw_rdy, sds_vld, sds_dat
  );
  modport master (
    output sdw_vld, sdw_dat, sdw_stb, sds_rdy,
    input  sdw_rdy, sds_vld, sds_dat
  );
`else
  modport slave (
    input  sdw_vld, sdw_dat, sds_rdy,
    output sdw_rdy, sds_vld, sds_dat
  );
  modport master (
    output sdw_vld, sdw_dat, sds_rdy,
    input  sdw_rdy, sds_vld, sds_dat
  );
`endif
endinterface

// File: rtl/sockit_spi_dws.sv
// rtl/sockit_spi_dws.sv - DW-to-SW data width serializer; SOCKIT_SPI_DWS_STRB_EN enables per-lane strobes
module sockit_spi_dws #(
  parameter int    DW     = 32,
  parameter int    SW     = 8,
  parameter string ENDIAN = "BIG"
) (
  input logic              ACLK,
  input logic              ARESETn,
  sockit_spi_dws_if.slave  bus
);
  localparam int N   = DW / SW;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam bit BIG = (ENDIAN == "BIG");

  logic [DW-1:0] data_q;
  logic          full;
  logic          last;
  logic          in_xfer;
  logic          out_xfer;
  int            sel;
  logic [SW-1:0] chunk;

  assign in_xfer  = bus.sdw_vld & bus.sdw_rdy;
  assign out_xfer = full & bus.sds_rdy;

  // Reload on the last chunk's handshake keeps the output stream bubble-free.
  assign bus.sdw_rdy = ~full | (bus.sds_rdy & last);
  assign bus.sds_vld = full;
  assign bus.sds_dat = chunk;

  always_comb begin
    chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == k) chunk = data_q[k*SW +: SW];
    end
  end

`ifdef SOCKIT_SPI_DWS_STRB_EN
  logic [N-1:0] mask_q;
  logic [N-1:0] lane_oh;

  assign full = |mask_q;
  assign last = $onehot(mask_q);

  // Pick the next pending lane: highest for BIG, lowest for LITTLE.
  always_comb begin
    sel = 0;
    if (BIG) begin
      for (int k = 0; k < N; k++) begin
        if (mask_q[k]) sel = k;
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (mask_q[k]) sel = k;
      end
    end
    lane_oh = '0;
    for (int k = 0; k < N; k++) begin
      lane_oh[k] = (sel == k);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      data_q <= '0;
      mask_q <= '0;
    end else if (in_xfer) begin
      data_q <= bus.sdw_dat;
      mask_q <= bus.sdw_stb;
    end else if (out_xfer) begin
      mask_q <= mask_q & ~lane_oh;
    end
  end
`else
  logic [CW-1:0] cnt_q;
  logic          full_q;

  assign full = full_q;
  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    sel = BIG ? (N - 1 - int'(cnt_q)) : int'(cnt_q);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (in_xfer) begin
      data_q <= bus.sdw_dat;
      cnt_q  <= '0;
      full_q <= 1'b1;
    end else if (out_xfer) begin
      if (last) begin
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
`endif
endmodule

// File: tb/tb_sockit_spi_dws.sv
// tb/tb_sockit_spi_dws.sv - directed bench for sockit_spi_dws (BIG, LITTLE and N==1 instances)
module tb_sockit_spi_dws;
  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  sockit_spi_dws_if #(.DW(32), .SW(8)) bif ();
  sockit_spi_dws_if #(.DW(32), .SW(8)) lif ();
  sockit_spi_dws_if #(.DW(8),  .SW(8)) oif ();

  sockit_spi_dws #(.DW(32), .SW(8), .ENDIAN("BIG"))    u_big (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bif));
  sockit_spi_dws #(.DW(32), .SW(8), .ENDIAN("LITTLE")) u_lit (.ACLK(ACLK), .ARESETn(ARESETn), .bus(lif));
  sockit_spi_dws #(.DW(8),  .SW(8), .ENDIAN("BIG"))    u_one (.ACLK(ACLK), .ARESETn(ARESETn), .bus(oif));

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  exp_big [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  exp_lit [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  exp_b2b [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
  logic        rdy_b2b [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0]  exp_cafe [4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
  logic [31:0] words [100];
  logic [7:0]  expq [$];
  logic [7:0]  got [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic samp;
    @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wi, k, cyc;
    logic pv;
    logic [7:0] pd;
    logic inx;

    bif.sdw_vld = 0; bif.sdw_dat = '0; bif.sds_rdy = 0;
    lif.sdw_vld = 0; lif.sdw_dat = '0; lif.sds_rdy = 0;
    oif.sdw_vld = 0; oif.sdw_dat = '0; oif.sds_rdy = 0;
`ifdef SOCKIT_SPI_DWS_STRB_EN
    bif.sdw_stb = 4'hF; lif.sdw_stb = 4'hF; oif.sdw_stb = 1'b1;
`endif

    // reset state
    samp;
    check("rst_vld", bif.sds_vld, 0);
    check("rst_dat", bif.sds_dat, 0);
    check("rst_rdy", bif.sdw_rdy, 1);
    tick;
    ARESETn = 1;
    samp;
    check("rel_rdy", bif.sdw_rdy, 1);
    check("rel_vld", lif.sds_vld, 0);

    // single word, both endians
    tick;
    bif.sdw_vld = 1; bif.sdw_dat = 32'h11223344; bif.sds_rdy = 1;
    lif.sdw_vld = 1; lif.sdw_dat = 32'h11223344; lif.sds_rdy = 1;
    samp;
    check("t1_rdy_big", bif.sdw_rdy, 1);
    check("t1_rdy_lit", lif.sdw_rdy, 1);
    tick;
    bif.sdw_vld = 0; lif.sdw_vld = 0;
    for (int i = 0; i < 4; i++) begin
      samp;
      check($sformatf("t1_big_vld%0d", i), bif.sds_vld, 1);
      check($sformatf("t1_big_dat%0d", i), bif.sds_dat, exp_big[i]);
      check($sformatf("t1_lit_dat%0d", i), lif.sds_dat, exp_lit[i]);
      tick;
    end
    samp;
    check("t1_big_idle", bif.sds_vld, 0);
    check("t1_lit_idle", lif.sds_vld, 0);

    // back-to-back words, no bubble
    tick;
    bif.sdw_vld = 1; bif.sdw_dat = 32'hA0A1A2A3;
    tick;
    bif.sdw_dat = 32'hB0B1B2B3;
    for (int i = 0; i < 8; i++) begin
      samp;
      check($sformatf("b2b_vld%0d", i), bif.sds_vld, 1);
      check($sformatf("b2b_dat%0d", i), bif.sds_dat, exp_b2b[i]);
      check($sformatf("b2b_rdy%0d", i), bif.sdw_rdy, rdy_b2b[i]);
      tick;
      if (i == 3) bif.sdw_vld = 0;
    end
    samp;
    check("b2b_idle", bif.sds_vld, 0);

    // N==1 register slice
    tick;
    oif.sdw_vld = 1; oif.sdw_dat = 8'h5A; oif.sds_rdy = 0;
    samp;
    check("one_rdy_empty", oif.sdw_rdy, 1);
    tick;
    oif.sdw_dat = 8'hC3;
    samp;
    check("one_vld", oif.sds_vld, 1);
    check("one_dat", oif.sds_dat, 8'h5A);
    check("one_rdy_stall", oif.sdw_rdy, 0);
    tick;
    oif.sds_rdy = 1;
    samp;
    check("one_dat_hold", oif.sds_dat, 8'h5A);
    check("one_rdy_go", oif.sdw_rdy, 1);
    tick;
    oif.sdw_vld = 0;
    samp;
    check("one_dat2", oif.sds_dat, 8'hC3);
    check("one_vld2", oif.sds_vld, 1);
    tick;
    samp;
    check("one_idle", oif.sds_vld, 0);

    // random output stalls over 100 words
    for (int w = 0; w < 100; w++) begin
      words[w] = $urandom;
      for (int c = 3; c >= 0; c--) expq.push_back(words[w][c*8 +: 8]);
    end
    wi = 0; k = 0; cyc = 0; pv = 0; pd = '0;
    tick;
    while (expq.size() != 0 && cyc < 5000) begin
      bif.sds_rdy = 1'($urandom_range(0, 1));
      bif.sdw_vld = (wi < 100);
      bif.sdw_dat = (wi < 100) ? words[wi] : 32'h0;
      samp;
      if (pv) begin
        check("stall_vld", bif.sds_vld, 1);
        check("stall_dat", bif.sds_dat, pd);
      end
      if (bif.sds_vld && !(k == 3 && bif.sds_rdy)) check("mid_rdy", bif.sdw_rdy, 0);
      inx = bif.sdw_vld & bif.sdw_rdy;
      if (bif.sds_vld && bif.sds_rdy) begin
        if (expq.size() != 0) check("rand_chunk", bif.sds_dat, expq.pop_front());
        else check("rand_extra", bif.sds_vld, 0);
        k = (k + 1) % 4;
      end
      pv = bif.sds_vld & ~bif.sds_rdy;
      pd = bif.sds_dat;
      if (inx) wi++;
      cyc++;
      tick;
    end
    bif.sdw_vld = 0;
    bif.sds_rdy = 1;
    check("rand_done", expq.size(), 0);
    check("rand_words", wi, 100);

    // reset in the middle of a word
    bif.sdw_vld = 1; bif.sdw_dat = 32'h11223344;
    tick;
    bif.sdw_vld = 0;
    samp;
    check("mr_dat0", bif.sds_dat, 8'h11);
    tick;
    samp;
    check("mr_dat1", bif.sds_dat, 8'h22);
    tick;
    ARESETn = 0;
    samp;
    check("mr_vld", bif.sds_vld, 0);
    check("mr_rdy", bif.sdw_rdy, 1);
    check("mr_dat", bif.sds_dat, 0);
    tick;
    ARESETn = 1;
    bif.sdw_vld = 1; bif.sdw_dat = 32'hCAFEBABE;
    tick;
    bif.sdw_vld = 0;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      samp;
      if (bif.sds_vld && bif.sds_rdy) got.push_back(bif.sds_dat);
      tick;
    end
    check("mr_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mr_chunk%0d", i), (i < got.size()) ? got[i] : 8'h00, exp_cafe[i]);
    end

`ifdef SOCKIT_SPI_DWS_STRB_EN
    // strobed lanes
    bif.sdw_vld = 1; bif.sdw_dat = 32'h11223344; bif.sdw_stb = 4'b1010;
    tick;
    bif.sdw_vld = 0; bif.sdw_stb = 4'hF;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      samp;
      if (bif.sds_vld && bif.sds_rdy) got.push_back(bif.sds_dat);
      tick;
    end
    check("stb_count", got.size(), 2);
    check("stb_chunk0", (got.size() > 0) ? got[0] : 8'h00, 8'h11);
    check("stb_chunk1", (got.size() > 1) ? got[1] : 8'h00, 8'h33);
    bif.sdw_vld = 1; bif.sdw_stb = 4'b0000;
    samp;
    check("stb0_rdy", bif.sdw_rdy, 1);
    tick;
    bif.sdw_vld = 0; bif.sdw_stb = 4'hF;
    samp;
    check("stb0_vld", bif.sds_vld, 0);
    tick;
    samp;
    check("stb0_vld2", bif.sds_vld, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
